// File: rtl/result_tfifo_pkg.sv
// Shared sizing helpers for the result-channel transparent FIFO.
package result_tfifo_pkg;

    localparam int DEF_NUM_SLOTS = 4;

    // Pointer width; a single slot still needs a 1-bit pointer.
    function automatic int ptr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int PTR_W = ptr_w(DEF_NUM_SLOTS);
    localparam int CNT_W = cnt_w(DEF_NUM_SLOTS);

endpackage

// File: rtl/result_tfifo_storage.sv
// Register-array storage: one synchronous write port, one async read port.
module result_tfifo_storage
    import result_tfifo_pkg::*;
#(
    parameter int BITWIDTH  = 32,
    parameter int NUM_SLOTS = DEF_NUM_SLOTS
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [ptr_w(NUM_SLOTS)-1:0]    waddr,
    input  logic [BITWIDTH-1:0]            wdata,
    input  logic [ptr_w(NUM_SLOTS)-1:0]    raddr,
    output logic [BITWIDTH-1:0]            rdata
);

    logic [BITWIDTH-1:0] mem [NUM_SLOTS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/result_tfifo.sv
// Transparent elastic FIFO on a divider result channel: bypass when empty,
// strict FIFO order otherwise, ins_ready independent of outs_ready.
module result_tfifo
    import result_tfifo_pkg::*;
#(
    parameter int BITWIDTH  = 32,
    parameter int NUM_SLOTS = DEF_NUM_SLOTS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BITWIDTH-1:0]           ins,
    input  logic                          ins_valid,
    output logic                          ins_ready,
    output logic [BITWIDTH-1:0]           outs,
    output logic                          outs_valid,
    input  logic                          outs_ready,
    output logic [cnt_w(NUM_SLOTS)-1:0]   count
);

    localparam int PW = ptr_w(NUM_SLOTS);
    localparam int CW = cnt_w(NUM_SLOTS);
    localparam logic [PW-1:0] LAST = PW'(NUM_SLOTS - 1);
    localparam logic [CW-1:0] FULL = CW'(NUM_SLOTS);

    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [BITWIDTH-1:0] rdata;
    logic                empty;
    logic                full;
    logic                accept_in;
    logic                accept_out;
    logic                bypass;
    logic                wr_en;
    logic                rd_en;

    assign empty      = (count == '0);
    assign full       = (count == FULL);
    assign ins_ready  = ~full;
    assign outs_valid = ins_valid | ~empty;
    assign outs       = empty ? ins : rdata;

    assign accept_in  = ins_valid & ins_ready;
    assign accept_out = outs_valid & outs_ready;
    assign bypass     = empty & accept_in & outs_ready;
    assign wr_en      = accept_in & ~bypass;
    assign rd_en      = accept_out & ~empty;

    result_tfifo_storage #(
        .BITWIDTH  (BITWIDTH),
        .NUM_SLOTS (NUM_SLOTS)
    ) u_storage (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (ins),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // Explicit compare-and-reset wrap so non-power-of-two depths work.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            end
            if (wr_en && !rd_en) begin
                count <= count + CW'(1);
            end else if (rd_en && !wr_en) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_result_tfifo.sv
// Directed and randomized checks of result_tfifo at depths 4, 3 and 5
// against a queue scoreboard.
module tb_result_tfifo;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] d4_ins = '0, d4_outs;
    logic        d4_iv = 0, d4_ir, d4_ov, d4_or = 0;
    logic [2:0]  d4_cnt;

    logic [31:0] d3_ins = '0, d3_outs;
    logic        d3_iv = 0, d3_ir, d3_ov, d3_or = 0;
    logic [1:0]  d3_cnt;

    logic [31:0] d5_ins = '0, d5_outs;
    logic        d5_iv = 0, d5_ir, d5_ov, d5_or = 0;
    logic [2:0]  d5_cnt;

    result_tfifo #(.BITWIDTH(32), .NUM_SLOTS(4)) u4 (
        .clk(clk), .rst(rst), .ins(d4_ins), .ins_valid(d4_iv),
        .ins_ready(d4_ir), .outs(d4_outs), .outs_valid(d4_ov),
        .outs_ready(d4_or), .count(d4_cnt)
    );

    result_tfifo #(.BITWIDTH(32), .NUM_SLOTS(3)) u3 (
        .clk(clk), .rst(rst), .ins(d3_ins), .ins_valid(d3_iv),
        .ins_ready(d3_ir), .outs(d3_outs), .outs_valid(d3_ov),
        .outs_ready(d3_or), .count(d3_cnt)
    );

    result_tfifo #(.BITWIDTH(32), .NUM_SLOTS(5)) u5 (
        .clk(clk), .rst(rst), .ins(d5_ins), .ins_valid(d5_iv),
        .ins_ready(d5_ir), .outs(d5_outs), .outs_valid(d5_ov),
        .outs_ready(d5_or), .count(d5_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] sb[$];
    logic [31:0] exp_v;

    initial begin
        int done;
        bit pend;
        bit hold;
        logic [31:0] held;

        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rst_ready", d4_ir, 1);
        chk("rst_count", d4_cnt, 0);
        chk("rst_ovalid", d4_ov, 0);

        // bypass: zero latency, count stays 0
        d4_iv = 1; d4_ins = 32'h2A; d4_or = 1;
        #1;
        chk("byp_outs", d4_outs, 32'h2A);
        chk("byp_ovalid", d4_ov, 1);
        step();
        chk("byp_count", d4_cnt, 0);

        // fill depth 4
        d4_or = 0;
        for (int i = 1; i <= 4; i++) begin
            d4_iv = 1; d4_ins = 32'(i);
            step();
            chk("fill_count", d4_cnt, 64'(i));
        end
        chk("full_ready", d4_ir, 0);
        d4_ins = 32'h5;
        #1;
        chk("full_head", d4_outs, 32'h1);
        step();
        chk("full_noacc", d4_cnt, 4);
        d4_iv = 0;

        // drain
        d4_or = 1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("drain_outs", d4_outs, 64'(i));
            chk("drain_ovalid", d4_ov, 1);
            step();
            chk("drain_count", d4_cnt, 64'(4 - i));
            chk("drain_ready", d4_ir, 1);
        end
        d4_or = 0;

        // depth 3: hold at 2, push/pop 10 cycles through wrap
        d3_or = 0;
        for (int i = 0; i < 2; i++) begin
            d3_iv = 1; d3_ins = 32'(100 + i);
            step();
        end
        chk("d3_pre_count", d3_cnt, 2);
        d3_or = 1;
        for (int k = 0; k < 10; k++) begin
            d3_iv = 1; d3_ins = 32'(102 + k);
            #1;
            chk("d3_outs", d3_outs, 64'(100 + k));
            step();
            chk("d3_count", d3_cnt, 2);
        end
        d3_or = 0;
        d3_ins = 32'h77;
        step();
        chk("d3_fill3", d3_cnt, 3);

        // reset mid-operation with live input
        rst = 1; d3_iv = 1; d3_ins = 32'hDEAD;
        step();
        rst = 0; d3_ins = 32'hBEEF;
        #1;
        chk("rst3_count", d3_cnt, 0);
        chk("rst3_ready", d3_ir, 1);
        chk("rst3_outs", d3_outs, 32'hBEEF);
        chk("rst3_ovalid", d3_ov, 1);
        d3_iv = 0;
        step();

        // depth 5 random traffic
        done = 0; pend = 0; hold = 0; held = '0;
        for (int cyc = 0; cyc < 60000 && done < 5000; cyc++) begin
            if (!pend) begin
                d5_iv = 1'($urandom_range(0, 1));
                d5_ins = $urandom;
            end
            d5_or = 1'($urandom_range(0, 1));
            #1;
            if (hold) begin
                chk("r_hold_valid", d5_ov, 1);
                chk("r_hold_data", d5_outs, held);
            end
            chk("r_count", d5_cnt, 64'(sb.size()));
            if (d5_iv && d5_ir) sb.push_back(d5_ins);
            pend = d5_iv && !d5_ir;
            if (d5_ov && d5_or) begin
                if (sb.size() == 0) begin
                    chk("r_spurious", 1, 0);
                end else begin
                    exp_v = sb.pop_front();
                    chk("r_data", d5_outs, exp_v);
                    done++;
                end
            end
            hold = d5_ov && !d5_or;
            held = d5_outs;
            step();
        end
        chk("r_done", 64'(done >= 5000), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
